vga_timing_generator: RTL and testbench

- Parametrised successor to the fixed 1024x768 VGA sync generator in the video path.
- All horizontal and vertical timings and sync polarities are set by parameters.
- Adds a pixel clock-enable, line and frame start strobes, and a prefetch coordinate port that runs LEAD enabled cycles ahead of the display outputs. The prefetch port hides the read latency of the spectrum/frame buffer.
- Sits between the pixel clock domain and the pixel renderer / DAC output register.

---
 rtl/vga_timing_if.sv | 35 +++
 rtl/vga_timing_generator.sv | 134 +++++++++++++
 tb/tb_vga_timing_generator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
//------------------------------------------------------------------------------
// Module      : vga_timing_if
// Description : Sync, blanking, strobe and prefetch coordinate bundle driven by
//               vga_timing_generator toward the renderer / DAC register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_timing_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           hSync;
    logic           vSync;
    logic           blank;
    logic [X_W-1:0] xPixel;
    logic [Y_W-1:0] yPixel;
    logic           lineStart;
    logic           frameStart;
    logic           fetchValid;
    logic [X_W-1:0] fetchX;
    logic [Y_W-1:0] fetchY;

    modport master (
        output hSync, vSync, blank, xPixel, yPixel,
        output lineStart, frameStart, fetchValid, fetchX, fetchY
    );

    modport slave (
        input hSync, vSync, blank, xPixel, yPixel,
        input lineStart, frameStart, fetchValid, fetchX, fetchY
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_generator.sv
//------------------------------------------------------------------------------
// Module      : vga_timing_generator
// Description : Parametrised VGA sync generator with pixel enable, line/frame
//               strobes and a prefetch port running LEAD cycles ahead.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing_generator #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BACK    = 160,
    parameter int H_NEG     = 1,
    parameter int V_VISIBLE = 768,
    parameter int V_FRONT   = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 29,
    parameter int V_NEG     = 1,
    parameter int LEAD      = 2
) (
    input  wire logic    inClock,
    input  wire logic    reset,
    input  wire logic    pixelEnable,
    vga_timing_if.master vga
);

    localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_h_cw    = (c_h_total > 1) ? $clog2(c_h_total) : 1;
    localparam int c_v_cw    = (c_v_total > 1) ? $clog2(c_v_total) : 1;
    localparam int c_x_w     = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
    localparam int c_y_w     = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;
    localparam int c_hs_lo   = H_VISIBLE + H_FRONT;
    localparam int c_hs_hi   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int c_vs_lo   = V_VISIBLE + V_FRONT;
    localparam int c_vs_hi   = V_VISIBLE + V_FRONT + V_SYNC;

    localparam logic [c_h_cw-1:0] c_h_last = c_h_cw'(c_h_total - 1);
    localparam logic [c_v_cw-1:0] c_v_last = c_v_cw'(c_v_total - 1);

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             blank;
        logic [c_x_w-1:0] x;
        logic [c_y_w-1:0] y;
        logic             line;
        logic             frame;
    } pix_t;

    // Inactive sync level equals the polarity flag: active-low sync idles high.
    localparam pix_t c_idle_pix = '{
        hs: 1'(H_NEG), vs: 1'(V_NEG), blank: 1'b1,
        x: '0, y: '0, line: 1'b0, frame: 1'b0
    };

    logic [c_h_cw-1:0] h_count_q, h_count_d;
    logic [c_v_cw-1:0] v_count_q, v_count_d;
    pix_t              fetch_q, fetch_d;
    pix_t              pipe_q [LEAD];
    pix_t              pipe_d [LEAD];
    pix_t              w_fetch_new;
    int                w_h_pos;
    int                w_v_pos;
    logic              w_visible;

    always_comb begin
        w_h_pos   = int'(h_count_q);
        w_v_pos   = int'(v_count_q);
        w_visible = (w_h_pos < H_VISIBLE) && (w_v_pos < V_VISIBLE);

        w_fetch_new.hs    = 1'(H_NEG) ^ ((w_h_pos >= c_hs_lo) && (w_h_pos < c_hs_hi));
        w_fetch_new.vs    = 1'(V_NEG) ^ ((w_v_pos >= c_vs_lo) && (w_v_pos < c_vs_hi));
        w_fetch_new.blank = ~w_visible;
        w_fetch_new.x     = w_visible ? c_x_w'(h_count_q) : '0;
        w_fetch_new.y     = w_visible ? c_y_w'(v_count_q) : '0;
        w_fetch_new.line  = (h_count_q == '0);
        w_fetch_new.frame = (h_count_q == '0) && (v_count_q == '0);
    end

    // Everything advances together on enabled cycles so fetch and display stay aligned.
    always_comb begin
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        fetch_d   = fetch_q;
        pipe_d    = pipe_q;
        if (pixelEnable) begin
            if (h_count_q == c_h_last) begin
                h_count_d = '0;
                v_count_d = (v_count_q == c_v_last) ? '0 : v_count_q + 1'b1;
            end else begin
                h_count_d = h_count_q + 1'b1;
            end
            fetch_d   = w_fetch_new;
            pipe_d[0] = fetch_q;
            for (int i = 1; i < LEAD; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge inClock) begin
        if (!reset) begin
            h_count_q <= '0;
            v_count_q <= '0;
            fetch_q   <= c_idle_pix;
            for (int i = 0; i < LEAD; i++) begin
                pipe_q[i] <= c_idle_pix;
            end
        end else begin
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
            fetch_q   <= fetch_d;
            for (int i = 0; i < LEAD; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign vga.hSync      = pipe_q[LEAD-1].hs;
    assign vga.vSync      = pipe_q[LEAD-1].vs;
    assign vga.blank      = pipe_q[LEAD-1].blank;
    assign vga.xPixel     = pipe_q[LEAD-1].x;
    assign vga.yPixel     = pipe_q[LEAD-1].y;
    assign vga.lineStart  = pipe_q[LEAD-1].line;
    assign vga.frameStart = pipe_q[LEAD-1].frame;
    assign vga.fetchValid = ~fetch_q.blank;
    assign vga.fetchX     = fetch_q.x;
    assign vga.fetchY     = fetch_q.y;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
//------------------------------------------------------------------------------
// Module      : tb_vga_timing_generator
// Description : Scoreboard bench for vga_timing_generator on a 14x8 raster.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_generator;

    localparam int HV = 8, HF = 2, HS = 3, HB = 1;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HN = 0, VN = 1, LD = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic [2:0] x;
        logic [1:0] y;
        logic       line;
        logic       frame;
        logic       fv;
        logic [2:0] fx;
        logic [1:0] fy;
    } obs_t;

    logic clk;
    logic reset;
    logic en;
    int   k;
    int   n_tests;
    int   n_fail;
    int   cyc;
    obs_t exp_q[$];

    vga_timing_if #(.X_W(3), .Y_W(2)) vif ();

    vga_timing_generator #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .H_NEG(HN),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .V_NEG(VN),
        .LEAD(LD)
    ) dut (
        .inClock    (clk),
        .reset      (reset),
        .pixelEnable(en),
        .vga        (vif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Raster position p counts pixels from frame start; outputs follow from p alone.
    function automatic obs_t model(input int kk);
        obs_t o;
        int   p, h, v;
        o = '{hs: 1'(HN), vs: 1'(VN), blank: 1'b1, x: 3'd0, y: 2'd0,
              line: 1'b0, frame: 1'b0, fv: 1'b0, fx: 3'd0, fy: 2'd0};
        if (kk >= 1) begin
            p = (kk - 1) % (HT * VT);
            h = p % HT;
            v = p / HT;
            o.fv = (h < HV) && (v < VV);
            o.fx = o.fv ? 3'(h) : 3'd0;
            o.fy = o.fv ? 2'(v) : 2'd0;
        end
        if (kk >= LD + 1) begin
            p = (kk - 1 - LD) % (HT * VT);
            h = p % HT;
            v = p / HT;
            o.hs    = 1'(HN) ^ (h >= HV + HF && h < HV + HF + HS);
            o.vs    = 1'(VN) ^ (v >= VV + VF && v < VV + VF + VS);
            o.blank = !((h < HV) && (v < VV));
            o.x     = o.blank ? 3'd0 : 3'(h);
            o.y     = o.blank ? 2'd0 : 2'(v);
            o.line  = (h == 0);
            o.frame = (p == 0);
        end
        return o;
    endfunction

    task automatic step(input bit r, input bit e);
        reset = r;
        en    = e;
        if (!r) k = 0;
        else if (e) k++;
        exp_q.push_back(model(k));
        @(negedge clk);
    endtask

    initial begin
        obs_t e, a;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            n_tests++;
            a = {vif.hSync, vif.vSync, vif.blank, vif.xPixel, vif.yPixel,
                 vif.lineStart, vif.frameStart, vif.fetchValid, vif.fetchX, vif.fetchY};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty cyc=%0d actual=%h required=expectation", cyc, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d actual=%b required=%b", cyc, a, e);
                end
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        k       = 0;
        reset   = 1'b0;
        en      = 1'b0;
        step(0, 0);
        step(0, 1);
        repeat (2 * HT * VT + 10) step(1, 1);
        for (int i = 0; i < 2 * HT * VT + 10; i++) step(1, (i % 2) == 0);
        step(0, 1);
        while (k != 2 * HT + 9) step(1, 1);
        step(0, 1);
        repeat (20) step(1, 1);
        step(0, 0);
        repeat (5) step(1, 0);
        repeat (3000) step($urandom_range(0, 299) != 0, 1'($urandom_range(0, 1)));
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
